shr_seq: RTL
============

# shr_seq

Multi-cycle logical shift-right unit with valid/ready handshakes on input and output. It is the right-shift counterpart to the combinational left shifter in the datapath component library. It shifts the operand one bit position per clock, so a shift costs at most DATAWIDTH+1 cycles and the block needs no wide barrel-shifter mux. Upstream schedulers feed it an operand and a shift amount, then collect the zero-filled result under backpressure.

## Interface
- DATAWIDTH, 8: bit width of `a`, `sh_amt` and `d`; legal range 2..64.
- Clk  in  1  rising-edge clock for all state.
- Rst  in  1  reset, asynchronous, active-low; all state clears while low.
- in_valid  in  1  `a` and `sh_amt` are valid this cycle.
- in_ready  out  1  block accepts an operand this cycle.
- a  in  DATAWIDTH  operand to shift.
- sh_amt  in  DATAWIDTH  shift amount, unsigned.
- out_valid  out  1  `d` holds a completed result.
- out_ready  in  1  consumer takes the result this cycle.
- d  out  DATAWIDTH  registered result, `a >> sh_amt`, zero-filled from the MSB.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE. Reset state is IDLE.
- Internal state:
  - acc: DATAWIDTH-bit working register.
  - cnt: $clog2(DATAWIDTH+1)-bit remaining-shift count.
- IDLE:
  - in_ready=1.
  - On in_valid: acc<=a, cnt<=min(sh_amt, DATAWIDTH), next state SHIFT.
- SHIFT:
  - in_ready=0.
  - If cnt!=0: acc<=acc>>1 with a 0 inserted at the MSB, cnt<=cnt-1, stay in SHIFT.
  - If cnt==0: d<=acc, next state DONE.
- DONE:
  - out_valid=1.
  - On out_ready: next state IDLE.
  - Otherwise hold; d and out_valid stay stable.
- Width and saturation rules:
  - The clamp to DATAWIDTH happens at capture.
  - Any sh_amt>=DATAWIDTH produces d=0. sh_amt is never truncated before the compare.
- d updates only on the SHIFT→DONE transition. It keeps its last value through IDLE and SHIFT until the next result.
- in_valid outside IDLE is ignored, and no operand is captured. An upstream source must hold in_valid until it sees in_ready.
- out_ready outside DONE is ignored.

## Timing
- Reset values: state=IDLE, acc=0, cnt=0, d=0, out_valid=0. in_ready=1 as soon as Rst is high.
- Both in_ready and out_valid are decoded from the state register only. There is no combinational path from in_valid or out_ready to any output.
- Latency:
  - An operand accepted at edge k with clamped count n raises out_valid after edge k+n+1.
  - sh_amt=0 gives 1 cycle. The worst case is DATAWIDTH+1 cycles.
- Handshake completion:
  - An input handshake completes at an edge where in_valid & in_ready.
  - An output handshake completes at an edge where out_valid & out_ready.
- Throughput:
  - After an output handshake at edge m, in_ready=1 in cycle m+1. The earliest next accept is edge m+1.
  - Minimum initiation interval is n+3 cycles with out_ready tied high.
- Reset mid-operation: asserting Rst in SHIFT or DONE immediately clears out_valid and d. Any in-flight operand is discarded, and no result is produced for it.
- Simultaneous events: in_valid in DONE while out_ready=1 is not accepted in that cycle. The source must still be asserting in_valid in the following IDLE cycle.

## Test plan
- Basic shift: DATAWIDTH=8, a=0xB4, sh_amt=3, out_ready=1. Required: d=0x16, out_valid rises exactly 4 cycles after accept and stays high for 1 cycle.
- Zero shift and full clamp:
  - a=0xB4, sh_amt=0 → d=0xB4 with 1-cycle latency.
  - sh_amt=8 → d=0x00 with 9-cycle latency.
  - sh_amt=0xC8 → d=0x00 with 9-cycle latency.
- Backpressure: a=0xFF, sh_amt=1, out_ready held low for 5 cycles. Required: d=0x7F and out_valid=1 stay stable throughout. A second in_valid with a=0x11 during this window is not captured (in_ready=0), and the next result after release is for the held request only.
- Back-to-back stream: 20 random (a, sh_amt) pairs, in_valid held until accepted, out_ready random at 50%. Required: every d equals the reference a>>sh_amt, in order, with no drops or duplicates.
- Reset mid-shift: a=0x80, sh_amt=7, drive Rst low 3 cycles after accept. Required: out_valid=0, d=0x00 and in_ready=1 within the same cycle Rst is low. After release, a=0x80, sh_amt=7 → d=0x01.
- Width sweep: repeat the basic shift and clamp cases at DATAWIDTH=2 and DATAWIDTH=32. For DATAWIDTH=32, a=0x80000000, sh_amt=31 → d=0x00000001 with 32-cycle latency.

Source files
------------

// File: rtl/shr_seq.sv
// shr_seq: multi-cycle logical shift-right, one bit per clock,
// with valid/ready handshakes on both sides.
module shr_seq #(
  parameter int DATAWIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] sh_amt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] d
);

  localparam int CW = $clog2(DATAWIDTH + 1);
  localparam logic [CW-1:0] CMAX = CW'(DATAWIDTH);
  localparam logic [DATAWIDTH:0] LIM = (DATAWIDTH + 1)'(DATAWIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DATAWIDTH-1:0] r_acc;
  logic [DATAWIDTH-1:0] r_d;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_cnt_ld;
  logic                 w_cap;
  logic                 w_shift;
  logic                 w_fin;

  // Full-width compare so large amounts saturate instead of wrapping.
  assign w_cnt_ld = ({1'b0, sh_amt} >= LIM) ? CMAX
                                            : sh_amt[CW-1:0];

  always_comb begin
    w_next  = r_state;
    w_cap   = 1'b0;
    w_shift = 1'b0;
    w_fin   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_cap  = 1'b1;
          w_next = SHIFT;
        end
      end
      SHIFT: begin
        if (r_cnt != '0) begin
          w_shift = 1'b1;
        end else begin
          w_fin  = 1'b1;
          w_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_d   <= '0;
    end else begin
      if (w_cap) begin
        r_acc <= a;
        r_cnt <= w_cnt_ld;
      end else if (w_shift) begin
        r_acc <= {1'b0, r_acc[DATAWIDTH-1:1]};
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_fin) begin
        r_d <= r_acc;
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign d         = r_d;

endmodule
